// File: rtl/mem_arb_pkg.sv
// Shared encodings and widths for the instruction/data memory arbiter.
// Holds the arbiter state encoding and the fixed bus data/mask widths.
package mem_arb_pkg;

  localparam int DATA_W  = 64;
  localparam int WMASK_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb.sv
// Two-port (I/D) to single-bus arbiter; one transaction outstanding, D preferred with I anti-starvation.
// Request issue is combinational in IDLE; response is forwarded the same cycle it arrives on the bus.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int D_STREAK_MAX = 4,
  parameter int ADDR_W       = 64
) (
  input  logic               clk,
  input  logic               rst,

  input  logic [ADDR_W-1:0]  im_req_addr,
  input  logic               im_req_valid,
  output logic               im_req_ready,
  output logic [DATA_W-1:0]  im_resp_rdata,
  output logic               im_resp_valid,
  input  logic               im_kill,

  input  logic [ADDR_W-1:0]  dm_req_addr,
  input  logic [DATA_W-1:0]  dm_req_wdata,
  input  logic [WMASK_W-1:0] dm_req_wmask,
  input  logic               dm_req_wen,
  input  logic               dm_req_valid,
  output logic               dm_req_ready,
  output logic [DATA_W-1:0]  dm_resp_rdata,
  output logic               dm_resp_valid,

  output logic [ADDR_W-1:0]  bm_req_addr,
  output logic [DATA_W-1:0]  bm_req_wdata,
  output logic [WMASK_W-1:0] bm_req_wmask,
  output logic               bm_req_wen,
  output logic               bm_req_valid,
  input  logic               bm_req_ready,
  input  logic [DATA_W-1:0]  bm_resp_rdata,
  input  logic               bm_resp_valid
);

  localparam int SW = $clog2(D_STREAK_MAX + 2);
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] d_streak;
  logic          kill_q;
  logic          grant_d, grant_i, issue;

  // D wins ties until it has taken STREAK_MAX grants in a row over a waiting I.
  assign grant_d = dm_req_valid && !(im_req_valid && (d_streak == STREAK_MAX));
  assign grant_i = im_req_valid && !grant_d;
  assign issue   = grant_d || grant_i;

  assign im_resp_rdata = bm_resp_rdata;
  assign dm_resp_rdata = bm_resp_rdata;

  always_comb begin
    state_nxt     = state;
    bm_req_valid  = 1'b0;
    bm_req_addr   = grant_d ? dm_req_addr : im_req_addr;
    bm_req_wdata  = grant_d ? dm_req_wdata : '0;
    bm_req_wmask  = grant_d ? dm_req_wmask : '0;
    bm_req_wen    = grant_d ? dm_req_wen : 1'b0;
    im_req_ready  = 1'b0;
    dm_req_ready  = 1'b0;
    im_resp_valid = 1'b0;
    dm_resp_valid = 1'b0;
    case (state)
      ARB_IDLE: begin
        bm_req_valid = issue;
        if (issue && bm_req_ready) begin
          dm_req_ready = grant_d;
          im_req_ready = grant_i;
          state_nxt    = grant_d ? ARB_WAIT_D : ARB_WAIT_I;
        end
      end
      ARB_WAIT_I: begin
        if (bm_resp_valid) begin
          // A kill arriving with the response itself still squashes it.
          im_resp_valid = !(kill_q || im_kill);
          state_nxt     = ARB_IDLE;
        end
      end
      ARB_WAIT_D: begin
        if (bm_resp_valid) begin
          dm_resp_valid = 1'b1;
          state_nxt     = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      d_streak <= '0;
      kill_q   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt == ARB_IDLE)
        kill_q <= 1'b0;
      else if (im_kill && ((state == ARB_WAIT_I) || im_req_ready))
        kill_q <= 1'b1;

      if (!im_req_valid || im_req_ready)
        d_streak <= '0;
      else if (dm_req_ready && (d_streak != STREAK_MAX))
        d_streak <= d_streak + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb: reset, priority, starvation, kill, write hold, reset mid-flight.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_W-1:0]  im_req_addr;
  logic               im_req_valid;
  logic               im_req_ready;
  logic [DATA_W-1:0]  im_resp_rdata;
  logic               im_resp_valid;
  logic               im_kill;
  logic [ADDR_W-1:0]  dm_req_addr;
  logic [DATA_W-1:0]  dm_req_wdata;
  logic [WMASK_W-1:0] dm_req_wmask;
  logic               dm_req_wen;
  logic               dm_req_valid;
  logic               dm_req_ready;
  logic [DATA_W-1:0]  dm_resp_rdata;
  logic               dm_resp_valid;
  logic [ADDR_W-1:0]  bm_req_addr;
  logic [DATA_W-1:0]  bm_req_wdata;
  logic [WMASK_W-1:0] bm_req_wmask;
  logic               bm_req_wen;
  logic               bm_req_valid;
  logic               bm_req_ready;
  logic [DATA_W-1:0]  bm_resp_rdata;
  logic               bm_resp_valid;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arb #(.D_STREAK_MAX(4), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .im_req_addr(im_req_addr), .im_req_valid(im_req_valid), .im_req_ready(im_req_ready),
    .im_resp_rdata(im_resp_rdata), .im_resp_valid(im_resp_valid), .im_kill(im_kill),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
    .dm_req_wen(dm_req_wen), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
    .bm_req_addr(bm_req_addr), .bm_req_wdata(bm_req_wdata), .bm_req_wmask(bm_req_wmask),
    .bm_req_wen(bm_req_wen), .bm_req_valid(bm_req_valid), .bm_req_ready(bm_req_ready),
    .bm_resp_rdata(bm_resp_rdata), .bm_resp_valid(bm_resp_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    im_req_addr = '0; im_req_valid = 0; im_kill = 0;
    dm_req_addr = '0; dm_req_wdata = '0; dm_req_wmask = '0; dm_req_wen = 0; dm_req_valid = 0;
    bm_req_ready = 0; bm_resp_rdata = '0; bm_resp_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    settle();
    n_checks++;
    if ({im_resp_valid, dm_resp_valid, im_req_ready, dm_req_ready, bm_req_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000",
               {im_resp_valid, dm_resp_valid, im_req_ready, dm_req_ready, bm_req_valid});
    end
  endtask

  task automatic test_i_only();
    logic saw_d = 1'b0;
    im_req_addr = 64'h8000_0000; im_req_valid = 1; bm_req_ready = 1;
    settle();
    n_checks++;
    if ({bm_req_valid, im_req_ready, dm_req_ready, bm_req_wen} !== 4'b1100 ||
        bm_req_addr !== 64'h8000_0000 || bm_req_wmask !== 8'h00) begin
      n_fail++;
      $display("FAIL i_only_issue: vld/ir/dr/wen=%b addr=%h mask=%h want 1100 80000000 00",
               {bm_req_valid, im_req_ready, dm_req_ready, bm_req_wen}, bm_req_addr, bm_req_wmask);
    end
    tick();
    im_req_valid = 0; bm_req_ready = 0;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++;
      if (im_resp_valid !== 1'b0 || bm_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL i_only_wait: im_resp_valid=%b bm_req_valid=%b want 0 0", im_resp_valid, bm_req_valid);
      end
      saw_d |= dm_resp_valid;
      tick();
    end
    bm_resp_valid = 1; bm_resp_rdata = 64'hDEAD_BEEF_0000_0013;
    settle();
    n_checks++;
    if (im_resp_valid !== 1'b1 || im_resp_rdata !== 64'hDEAD_BEEF_0000_0013) begin
      n_fail++;
      $display("FAIL i_only_resp: valid=%b data=%h want 1 deadbeef00000013", im_resp_valid, im_resp_rdata);
    end
    saw_d |= dm_resp_valid;
    tick();
    bm_resp_valid = 0;
    settle();
    saw_d |= dm_resp_valid;
    n_checks++;
    if (im_resp_valid !== 1'b0 || saw_d !== 1'b0) begin
      n_fail++;
      $display("FAIL i_only_after: im_resp_valid=%b dm_seen=%b want 0 0", im_resp_valid, saw_d);
    end
  endtask

  task automatic test_d_priority();
    im_req_addr = 64'h1000; im_req_valid = 1;
    dm_req_addr = 64'h2000; dm_req_valid = 1; dm_req_wen = 0;
    bm_req_ready = 1;
    settle();
    n_checks++;
    if (bm_req_addr !== 64'h2000 || dm_req_ready !== 1'b1 || im_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_d_first: addr=%h dr=%b ir=%b want 2000 1 0", bm_req_addr, dm_req_ready, im_req_ready);
    end
    tick();
    dm_req_valid = 0;
    bm_resp_valid = 1; bm_resp_rdata = 64'h0000_0000_CAFE_0001;
    settle();
    n_checks++;
    if (dm_resp_valid !== 1'b1 || dm_resp_rdata !== 64'h0000_0000_CAFE_0001 ||
        bm_req_valid !== 1'b0 || im_req_ready !== 1'b0 || im_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_d_resp: dv=%b data=%h bv=%b ir=%b iv=%b want 1 cafe0001 0 0 0",
               dm_resp_valid, dm_resp_rdata, bm_req_valid, im_req_ready, im_resp_valid);
    end
    tick();
    bm_resp_valid = 0;
    settle();
    n_checks++;
    if (bm_req_valid !== 1'b1 || bm_req_addr !== 64'h1000 || im_req_ready !== 1'b1 || bm_req_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_i_second: bv=%b addr=%h ir=%b wen=%b want 1 1000 1 0",
               bm_req_valid, bm_req_addr, im_req_ready, bm_req_wen);
    end
    tick();
    im_req_valid = 0;
    bm_resp_valid = 1; bm_resp_rdata = 64'h0000_0000_CAFE_0002;
    settle();
    n_checks++;
    if (im_resp_valid !== 1'b1 || im_resp_rdata !== 64'h0000_0000_CAFE_0002 || dm_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_i_resp: iv=%b data=%h dv=%b want 1 cafe0002 0", im_resp_valid, im_resp_rdata, dm_resp_valid);
    end
    tick();
    clear_inputs();
  endtask

  // Both sides held valid with a 1-cycle bus: every grant takes exactly two cycles.
  task automatic test_starvation();
    logic [5:0] exp_d = 6'b101111;
    im_req_addr = 64'h1111; im_req_valid = 1;
    dm_req_addr = 64'h2222; dm_req_valid = 1;
    bm_req_ready = 1;
    for (int g = 0; g < 6; g++) begin
      bm_resp_valid = 0;
      settle();
      n_checks++;
      if (bm_req_valid !== 1'b1 || dm_req_ready !== exp_d[g] || im_req_ready !== !exp_d[g] ||
          bm_req_addr !== (exp_d[g] ? 64'h2222 : 64'h1111)) begin
        n_fail++;
        $display("FAIL starve_grant%0d: bv=%b dr=%b ir=%b addr=%h want D=%b", g,
                 bm_req_valid, dm_req_ready, im_req_ready, bm_req_addr, exp_d[g]);
      end
      tick();
      bm_resp_valid = 1; bm_resp_rdata = 64'(g);
      settle();
      n_checks++;
      if (dm_resp_valid !== exp_d[g] || im_resp_valid !== !exp_d[g]) begin
        n_fail++;
        $display("FAIL starve_resp%0d: dv=%b iv=%b want D=%b", g, dm_resp_valid, im_resp_valid, exp_d[g]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_kill();
    im_req_addr = 64'h4000; im_req_valid = 1; bm_req_ready = 1;
    tick();
    im_req_valid = 0; bm_req_ready = 0;
    im_kill = 1;
    tick();
    im_kill = 0;
    bm_resp_valid = 1; bm_resp_rdata = 64'h5555;
    settle();
    n_checks++;
    if (im_resp_valid !== 1'b0 || dm_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_squash: iv=%b dv=%b want 0 0", im_resp_valid, dm_resp_valid);
    end
    tick();
    bm_resp_valid = 0;
    dm_req_addr = 64'h6000; dm_req_valid = 1; bm_req_ready = 1;
    settle();
    n_checks++;
    if (bm_req_valid !== 1'b1 || dm_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_idle_next: bv=%b dr=%b want 1 1", bm_req_valid, dm_req_ready);
    end
    tick();
    dm_req_valid = 0; bm_req_ready = 0;
    im_kill = 1;
    bm_resp_valid = 1; bm_resp_rdata = 64'h7777;
    settle();
    n_checks++;
    if (dm_resp_valid !== 1'b1 || dm_resp_rdata !== 64'h7777) begin
      n_fail++;
      $display("FAIL kill_d_unaffected: dv=%b data=%h want 1 7777", dm_resp_valid, dm_resp_rdata);
    end
    tick();
    im_kill = 0; bm_resp_valid = 0;
    im_req_valid = 1; bm_req_ready = 1;
    tick();
    im_req_valid = 0; bm_req_ready = 0;
    bm_resp_valid = 1; bm_resp_rdata = 64'h8888;
    settle();
    n_checks++;
    if (im_resp_valid !== 1'b1 || im_resp_rdata !== 64'h8888) begin
      n_fail++;
      $display("FAIL kill_cleared: iv=%b data=%h want 1 8888", im_resp_valid, im_resp_rdata);
    end
    tick();
    bm_resp_valid = 0;
    im_req_valid = 1; bm_req_ready = 1; im_kill = 1;
    tick();
    im_req_valid = 0; bm_req_ready = 0; im_kill = 0;
    bm_resp_valid = 1;
    settle();
    n_checks++;
    if (im_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_at_accept: iv=%b want 0", im_resp_valid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_d_write();
    dm_req_addr = 64'h9000; dm_req_wdata = 64'h1122_3344_5566_7788;
    dm_req_wmask = 8'h0F; dm_req_wen = 1; dm_req_valid = 1; bm_req_ready = 0;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++;
      if (bm_req_valid !== 1'b1 || bm_req_addr !== 64'h9000 || bm_req_wdata !== 64'h1122_3344_5566_7788 ||
          bm_req_wmask !== 8'h0F || bm_req_wen !== 1'b1 || dm_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL write_hold%0d: bv=%b addr=%h wd=%h m=%h wen=%b dr=%b", c,
                 bm_req_valid, bm_req_addr, bm_req_wdata, bm_req_wmask, bm_req_wen, dm_req_ready);
      end
      tick();
    end
    bm_req_ready = 1;
    settle();
    n_checks++;
    if (dm_req_ready !== 1'b1 || bm_req_wdata !== 64'h1122_3344_5566_7788) begin
      n_fail++;
      $display("FAIL write_accept: dr=%b wd=%h want 1 1122334455667788", dm_req_ready, bm_req_wdata);
    end
    tick();
    bm_req_ready = 0;
    settle();
    n_checks++;
    if (dm_req_ready !== 1'b0 || bm_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_wait: dr=%b bv=%b want 0 0", dm_req_ready, bm_req_valid);
    end
    dm_req_valid = 0;
    bm_resp_valid = 1; bm_resp_rdata = '0;
    settle();
    n_checks++;
    if (dm_resp_valid !== 1'b1 || im_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ack: dv=%b iv=%b want 1 0", dm_resp_valid, im_resp_valid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    dm_req_addr = 64'hA000; dm_req_valid = 1; bm_req_ready = 1;
    tick();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    bm_resp_valid = 1; bm_resp_rdata = 64'hBAD;
    settle();
    n_checks++;
    if (dm_resp_valid !== 1'b0 || im_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stray_resp: dv=%b iv=%b want 0 0", dm_resp_valid, im_resp_valid);
    end
    tick();
    settle();
    n_checks++;
    if (dm_resp_valid !== 1'b0 || im_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stray_idle: dv=%b iv=%b want 0 0", dm_resp_valid, im_resp_valid);
    end
    bm_resp_valid = 0;
    im_req_addr = 64'hB000; im_req_valid = 1; bm_req_ready = 1;
    settle();
    n_checks++;
    if (bm_req_valid !== 1'b1 || im_req_ready !== 1'b1 || bm_req_addr !== 64'hB000) begin
      n_fail++;
      $display("FAIL reset_back_idle: bv=%b ir=%b addr=%h want 1 1 b000", bm_req_valid, im_req_ready, bm_req_addr);
    end
    tick();
    clear_inputs();
    bm_resp_valid = 1;
    tick();
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_i_only();
    test_d_priority();
    test_starvation();
    test_kill();
    test_d_write();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
